// File: rtl/ctrl_systolic_sequencer_if.sv
// Command and memory-side signal bundle for the systolic run sequencer.
// master = host/command side, slave = the sequencer itself.
interface ctrl_systolic_sequencer_if #(
    parameter int unsigned ADDRESSSIZE = 10,
    parameter int unsigned CNT_BW      = 10
);
    logic                   start;
    logic [CNT_BW-1:0]      num_vectors;
    logic [ADDRESSSIZE-1:0] w_base;
    logic [ADDRESSSIZE-1:0] d_base;
    logic [ADDRESSSIZE-1:0] r_base;
    logic                   w_re;
    logic [ADDRESSSIZE-1:0] w_addr;
    logic                   we_rl;
    logic                   ub_re;
    logic [ADDRESSSIZE-1:0] ub_addr;
    logic                   din_valid;
    logic                   res_we;
    logic [ADDRESSSIZE-1:0] res_addr;
    logic                   busy;
    logic                   done;

    modport master (
        output start, num_vectors, w_base, d_base, r_base,
        input  w_re, w_addr, we_rl, ub_re, ub_addr, din_valid,
        input  res_we, res_addr, busy, done
    );

    modport slave (
        input  start, num_vectors, w_base, d_base, r_base,
        output w_re, w_addr, we_rl, ub_re, ub_addr, din_valid,
        output res_we, res_addr, busy, done
    );
endinterface

// File: rtl/ctrl_systolic_sequencer.sv
// Run-level controller: loads one weight tile, streams N UB vectors into data setup
// and writes N results to the result buffer after the fixed array latency.
module ctrl_systolic_sequencer #(
    parameter int unsigned ADDRESSSIZE = 10,
    parameter int unsigned CNT_BW      = 10,
    parameter int unsigned RES_LATENCY = 24
) (
    input logic                      clk,
    input logic                      rst,
    ctrl_systolic_sequencer_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StLoadW, StLatchW, StStream, StDrain, StFin} state_e;

    localparam logic [CNT_BW-1:0] CntOne = 1;

    state_e                 state_q, state_d;
    logic [CNT_BW-1:0]      n_q, n_d;
    logic [ADDRESSSIZE-1:0] w_base_q, w_base_d;
    logic [ADDRESSSIZE-1:0] d_base_q, d_base_d;
    logic [ADDRESSSIZE-1:0] r_base_q, r_base_d;
    logic [CNT_BW-1:0]      i_q, i_d;
    logic [CNT_BW-1:0]      j_q, j_d;

    logic                   w_re_q, w_re_d;
    logic [ADDRESSSIZE-1:0] w_addr_q, w_addr_d;
    logic                   we_rl_q, we_rl_d;
    logic                   ub_re_q, ub_re_d;
    logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d;
    logic                   din_valid_q, din_valid_d;
    logic [ADDRESSSIZE-1:0] res_addr_q, res_addr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Result-valid delay line; sr_ext[RES_LATENCY] is res_we, sr_ext[RES_LATENCY-1] its next value.
    logic [RES_LATENCY-1:0] sr_q;
    logic [RES_LATENCY:0]   sr_ext;
    logic                   res_we_next;

    assign sr_ext      = {sr_q, din_valid_q};
    assign res_we_next = sr_ext[RES_LATENCY-1];

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        w_base_d    = w_base_q;
        d_base_d    = d_base_q;
        r_base_d    = r_base_q;
        i_d         = i_q;
        j_d         = j_q;
        w_re_d      = 1'b0;
        w_addr_d    = w_addr_q;
        we_rl_d     = 1'b0;
        ub_re_d     = 1'b0;
        ub_addr_d   = ub_addr_q;
        din_valid_d = ub_re_q;
        res_addr_d  = res_addr_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        // Address is set up alongside the strobe so it is valid during the write cycle.
        if (res_we_next) begin
            res_addr_d = r_base_q + ADDRESSSIZE'(j_q);
            j_d        = j_q + CntOne;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.num_vectors != '0) begin
                        n_d      = bus.num_vectors;
                        w_base_d = bus.w_base;
                        d_base_d = bus.d_base;
                        r_base_d = bus.r_base;
                        i_d      = '0;
                        j_d      = '0;
                        state_d  = StLoadW;
                    end else begin
                        state_d  = StFin;
                    end
                end
            end
            StLoadW: begin
                w_re_d   = 1'b1;
                w_addr_d = w_base_q;
                busy_d   = 1'b1;
                state_d  = StLatchW;
            end
            StLatchW: begin
                we_rl_d = 1'b1;
                busy_d  = 1'b1;
                state_d = StStream;
            end
            StStream: begin
                ub_re_d   = 1'b1;
                ub_addr_d = d_base_q + ADDRESSSIZE'(i_q);
                i_d       = i_q + CntOne;
                busy_d    = 1'b1;
                if (i_q == n_q - CntOne) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                busy_d = 1'b1;
                if (res_we_next && (j_q == n_q - CntOne)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            n_q         <= '0;
            w_base_q    <= '0;
            d_base_q    <= '0;
            r_base_q    <= '0;
            i_q         <= '0;
            j_q         <= '0;
            w_re_q      <= 1'b0;
            w_addr_q    <= '0;
            we_rl_q     <= 1'b0;
            ub_re_q     <= 1'b0;
            ub_addr_q   <= '0;
            din_valid_q <= 1'b0;
            res_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sr_q        <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            w_base_q    <= w_base_d;
            d_base_q    <= d_base_d;
            r_base_q    <= r_base_d;
            i_q         <= i_d;
            j_q         <= j_d;
            w_re_q      <= w_re_d;
            w_addr_q    <= w_addr_d;
            we_rl_q     <= we_rl_d;
            ub_re_q     <= ub_re_d;
            ub_addr_q   <= ub_addr_d;
            din_valid_q <= din_valid_d;
            res_addr_q  <= res_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sr_q        <= sr_ext[RES_LATENCY-1:0];
        end
    end

    assign bus.w_re      = w_re_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.we_rl     = we_rl_q;
    assign bus.ub_re     = ub_re_q;
    assign bus.ub_addr   = ub_addr_q;
    assign bus.din_valid = din_valid_q;
    assign bus.res_we    = sr_ext[RES_LATENCY];
    assign bus.res_addr  = res_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
